// File: rtl/writeback.sv
// writeback: final stage; picks ALU/load data, writes the register file, services ECALLs.
// Define WB_TRACE_EN to print a retire trace in simulation.
module writeback #(
    parameter int XLEN         = 64,
    parameter int REG_ADDR_W   = 5,
    parameter int RETIRE_CNT_W = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    writeback_enable,
    input  logic                    memory_done,
    input  logic [XLEN-1:0]         pc,
    input  logic [31:0]             instruction,
    input  logic [REG_ADDR_W-1:0]   rd_addr,
    input  logic                    reg_write,
    input  logic                    mem_read,
    input  logic                    is_ecall,
    input  logic [XLEN-1:0]         alu_data,
    input  logic [XLEN-1:0]         loaded_data,
    input  logic                    ecall_ack,
    input  logic [XLEN-1:0]         ecall_result,
    input  logic                    enable_logging,
    output logic                    mem_wb_status,
    output logic                    reg_write_enable,
    output logic [REG_ADDR_W-1:0]   reg_write_addr,
    output logic [XLEN-1:0]         reg_write_data,
    output logic                    ecall_request,
    output logic [XLEN-1:0]         ecall_pc,
    output logic                    writeback_done,
    output logic [XLEN-1:0]         retired_pc,
    output logic [RETIRE_CNT_W-1:0] retired_count
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        ECALL_WAIT
    } state_t;

    state_t state;
    state_t state_next;

    logic                  accept;
    logic                  in_write;
    logic                  in_ecall;
    logic [XLEN-1:0]       pc_q;
    logic [31:0]           instr_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  rw_q;
    logic [XLEN-1:0]       data_q;

    assign in_write      = (state == WRITE);
    assign in_ecall      = (state == ECALL_WAIT);
    assign mem_wb_status = in_ecall;
    assign accept        = memory_done && writeback_enable && !mem_wb_status;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, WRITE: begin
                if (accept) begin
                    state_next = is_ecall ? ECALL_WAIT : WRITE;
                end else begin
                    state_next = IDLE;
                end
            end
            ECALL_WAIT: begin
                if (ecall_ack) begin
                    state_next = WRITE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The ECALL result is retired as an ordinary write to x10.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            instr_q <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            data_q  <= '0;
        end else if (accept) begin
            pc_q    <= pc;
            instr_q <= instruction;
            rd_q    <= rd_addr;
            rw_q    <= reg_write;
            data_q  <= mem_read ? loaded_data : alu_data;
        end else if (in_ecall && ecall_ack) begin
            rd_q    <= REG_ADDR_W'(10);
            rw_q    <= 1'b1;
            data_q  <= ecall_result;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_count <= '0;
        end else if (in_write) begin
            retired_count <= retired_count + 1'b1;
        end
    end

    assign reg_write_enable = in_write && rw_q && (rd_q != '0);
    assign reg_write_addr   = in_write ? rd_q : '0;
    assign reg_write_data   = in_write ? data_q : '0;
    assign writeback_done   = in_write;
    assign retired_pc       = in_write ? pc_q : '0;
    assign ecall_request    = in_ecall;
    assign ecall_pc         = in_ecall ? pc_q : '0;

`ifdef WB_TRACE_EN
    logic ecall_seen;

    always @(posedge clk) begin
        if (writeback_done && enable_logging) begin
            $display("%0t wb pc=%h insn=%h rd=%0d data=%h we=%0b",
                     $time, retired_pc, instr_q, rd_q, data_q,
                     reg_write_enable);
        end
        if (in_ecall && !ecall_seen && enable_logging) begin
            $display("%0t ecall pc=%h insn=%h", $time, pc_q, instr_q);
        end
        ecall_seen <= in_ecall;
    end
`else
    logic unused_trace;
    assign unused_trace = ^{enable_logging, instr_q};
`endif

endmodule

// File: tb/tb_writeback.sv
// tb_writeback: randomized scoreboard bench for the writeback stage.
// Expected retires are queued by stimulus and checked by a negedge monitor.
module tb_writeback;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          writeback_enable;
    logic          memory_done;
    logic [63:0]   pc;
    logic [31:0]   instruction;
    logic [4:0]    rd_addr;
    logic          reg_write;
    logic          mem_read;
    logic          is_ecall;
    logic [63:0]   alu_data;
    logic [63:0]   loaded_data;
    logic          ecall_ack;
    logic [63:0]   ecall_result;
    logic          enable_logging;
    logic          mem_wb_status;
    logic          reg_write_enable;
    logic [4:0]    reg_write_addr;
    logic [63:0]   reg_write_data;
    logic          ecall_request;
    logic [63:0]   ecall_pc;
    logic          writeback_done;
    logic [63:0]   retired_pc;
    logic [CW-1:0] retired_count;

    writeback #(.XLEN(64), .REG_ADDR_W(5), .RETIRE_CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .writeback_enable(writeback_enable), .memory_done(memory_done),
        .pc(pc), .instruction(instruction), .rd_addr(rd_addr),
        .reg_write(reg_write), .mem_read(mem_read), .is_ecall(is_ecall),
        .alu_data(alu_data), .loaded_data(loaded_data),
        .ecall_ack(ecall_ack), .ecall_result(ecall_result),
        .enable_logging(enable_logging), .mem_wb_status(mem_wb_status),
        .reg_write_enable(reg_write_enable),
        .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
        .ecall_request(ecall_request), .ecall_pc(ecall_pc),
        .writeback_done(writeback_done), .retired_pc(retired_pc),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]   pc;
        logic          we;
        logic [4:0]    addr;
        logic [63:0]   data;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          q[$];
    exp_t          e;
    logic [CW-1:0] model_cnt;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] p, input logic we,
                        input logic [4:0] a, input logic [63:0] d);
        q.push_back('{p, we, a, d, model_cnt});
        model_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    // One cycle of memory_done; the stage is never stalled when called.
    task automatic issue(input bit ec, input logic [4:0] rd, input bit rw,
                         input bit mr, input logic [63:0] alu,
                         input logic [63:0] ld, input logic [63:0] pcv,
                         input bit en, input bit ack);
        memory_done      = 1'b1;
        writeback_enable = en;
        is_ecall         = ec;
        rd_addr          = rd;
        reg_write        = rw;
        mem_read         = mr;
        alu_data         = alu;
        loaded_data      = ld;
        pc               = pcv;
        instruction      = $urandom;
        ecall_ack        = ack;
        ecall_result     = r64();
        if (en && !ec) push(pcv, rw && (rd != 0), rd, mr ? ld : alu);
        step();
        memory_done = 1'b0;
        ecall_ack   = 1'b0;
    endtask

    // Stall for n cycles with ignored memory_done traffic, then ack.
    task automatic ecall_finish(input logic [63:0] pcv, input int n,
                                input logic [63:0] res, input bit direct);
        for (int i = 0; i < n; i++) begin
            memory_done      = 1'($urandom);
            writeback_enable = 1'($urandom);
            is_ecall         = 1'($urandom);
            rd_addr          = 5'($urandom);
            alu_data         = r64();
            step();
            if (direct) begin
                @(negedge clk);
                chk("stall_held", 64'(mem_wb_status), 64'd1);
                chk("ecall_req_held", 64'(ecall_request), 64'd1);
            end
        end
        memory_done      = 1'b0;
        writeback_enable = 1'b1;
        ecall_ack        = 1'b1;
        ecall_result     = res;
        push(pcv, 1'b1, 5'd10, res);
        step();
        ecall_ack = 1'b0;
        if (direct) begin
            @(negedge clk);
            chk("stall_release", 64'(mem_wb_status), 64'd0);
            chk("ecall_req_drop", 64'(ecall_request), 64'd0);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (writeback_done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_retire: got pc %h expected none",
                             retired_pc);
                end else begin
                    e = q.pop_front();
                    chk("retired_pc", retired_pc, e.pc);
                    chk("wr_en", 64'(reg_write_enable), 64'(e.we));
                    chk("wr_addr", 64'(reg_write_addr), 64'(e.addr));
                    chk("wr_data", reg_write_data, e.data);
                    chk("count", 64'(retired_count), 64'(e.cnt));
                end
            end else if (reg_write_enable) begin
                chk("stray_wr_en", 64'(reg_write_enable), 64'd0);
            end
        end
    end

    initial begin
        logic [63:0] p;
        int          k;
        reset            = 1'b0;
        writeback_enable = 1'b1;
        memory_done      = 1'b0;
        pc               = '0;
        instruction      = '0;
        rd_addr          = '0;
        reg_write        = 1'b0;
        mem_read         = 1'b0;
        is_ecall         = 1'b0;
        alu_data         = '0;
        loaded_data      = '0;
        ecall_ack        = 1'b0;
        ecall_result     = '0;
        enable_logging   = 1'b1;
        model_cnt        = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en", 64'(reg_write_enable), 64'd0);
        chk("rst_done", 64'(writeback_done), 64'd0);
        chk("rst_stall", 64'(mem_wb_status), 64'd0);
        chk("rst_count", 64'(retired_count), 64'd0);
        step();
        reset = 1'b1;
        step();

        // Reset while an ECALL is pending.
        issue(1, 5'd0, 0, 0, 0, 0, 64'h40, 1, 0);
        @(negedge clk);
        chk("pre_rst_req", 64'(ecall_request), 64'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_req", 64'(ecall_request), 64'd0);
        chk("async_rst_stall", 64'(mem_wb_status), 64'd0);
        step();
        reset = 1'b1;
        model_cnt = '0;
        @(negedge clk);
        chk("post_rst_count", 64'(retired_count), 64'd0);
        chk("post_rst_done", 64'(writeback_done), 64'd0);
        chk("post_rst_ecall_pc", ecall_pc, 64'd0);

        issue(0, 5'd5, 1, 0, 64'h1234, 64'hFFFF, 64'h100, 1, 0);
        @(negedge clk);
        chk("alu_we", 64'(reg_write_enable), 64'd1);
        chk("alu_addr", 64'(reg_write_addr), 64'd5);
        chk("alu_data", reg_write_data, 64'h1234);
        chk("alu_done", 64'(writeback_done), 64'd1);

        issue(0, 5'd0, 1, 1, 64'h5, 64'hDEAD, 64'h104, 1, 0);
        @(negedge clk);
        chk("rd0_we", 64'(reg_write_enable), 64'd0);
        chk("rd0_done", 64'(writeback_done), 64'd1);

        for (int i = 1; i <= 3; i++) begin
            issue(0, 5'(i), 1, 0, r64(), r64(), 64'h108 + 64'(4 * i), 1, 0);
            @(negedge clk);
            chk("b2b_stall", 64'(mem_wb_status), 64'd0);
            chk("b2b_done", 64'(writeback_done), 64'd1);
        end

        issue(1, 5'd17, 0, 0, 0, 0, 64'h80, 1, 0);
        @(negedge clk);
        chk("ecall_stall", 64'(mem_wb_status), 64'd1);
        chk("ecall_req", 64'(ecall_request), 64'd1);
        chk("ecall_pc", ecall_pc, 64'h80);
        ecall_finish(64'h80, 10, 64'h2A, 1);

        for (int i = 0; i < 10; i++) begin
            issue(0, 5'($urandom), 1'($urandom), 1'($urandom), r64(), r64(),
                  64'h200 + 64'(4 * i), 1, 0);
        end
        step();
        step();
        chk("wrap_count", 64'(retired_count), 64'd0);

        // Randomized mix with stray acks and enable gaps.
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 9);
            p = r64();
            if (k == 0) begin
                ecall_ack    = 1'($urandom);
                ecall_result = r64();
                step();
                ecall_ack = 1'b0;
            end else if (k == 1) begin
                issue(1, 5'($urandom), 1'($urandom), 0, r64(), r64(), p,
                      1'b1, 1'($urandom));
                ecall_finish(p, $urandom_range(0, 5), r64(), 0);
            end else begin
                issue(0, 5'($urandom), 1'($urandom), 1'($urandom), r64(),
                      r64(), p, $urandom_range(0, 6) != 0, 1'($urandom));
            end
        end

        for (int i = 0; i < 10 && q.size() != 0; i++) step();
        chk("queue_drained", 64'(q.size()), 64'd0);
        step();
        chk("final_count", 64'(retired_count), 64'(model_cnt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
